nf_debug_stats: RTL and testbench
=================================

# nf_debug_stats

Per-port traffic statistics collector that sits directly upstream of the debug packet generator and drives its 384-bit `debug_vector` input. It passively taps the 10G MAC RX stream and the TX stream (valid/ready/keep/last), accumulates frame, byte, error and stall counters, and publishes them as a coherent snapshot on request. It never drives or back-pressures either stream.

## Interface
- `MIN_LEN`, 64: shortest legal RX frame in bytes.
- `MAX_LEN`, 1518: longest legal RX frame in bytes.
- `CLEAR_ON_SNAPSHOT`, 0: 1 = counters restart after each snapshot; 0 = free-running.

- `clk156` in 1: 156.25 MHz clock; only clock.
- `reset` in 1: asynchronous, active-high reset.
- `m_axis_rx_tkeep` in 8: RX tap byte enables.
- `m_axis_rx_tlast` in 1: RX tap end of frame.
- `m_axis_rx_tuser` in 1: RX tap frame-good flag, sampled on the last beat.
- `m_axis_rx_tvalid` in 1: RX tap beat valid. RX has no ready signal.
- `s_axis_tx_tkeep` in 8: TX tap byte enables.
- `s_axis_tx_tlast` in 1: TX tap end of frame.
- `s_axis_tx_tvalid` in 1: TX tap valid.
- `s_axis_tx_tready` in 1: TX tap ready.
- `snapshot` in 1: single-cycle request to publish the counters.
- `debug_vector` out 384: registered snapshot.
- `snapshot_done` out 1: one-cycle pulse when `debug_vector` updates.

## Operation
- **Beat qualification**
  - RX beat = `m_axis_rx_tvalid`.
  - TX beat = `s_axis_tx_tvalid & s_axis_tx_tready`.
  - `tlast`, `tkeep` and `tuser` are ignored on unqualified cycles.
- **Beat bytes**: popcount(`tkeep`), range 0–8.
- **Per-direction meter**, states IDLE and IN_FRAME:
  - A qualified beat with `tlast`=0 moves to (or stays in) IN_FRAME and adds its bytes to a 16-bit length accumulator, which saturates at 0xFFFF.
  - A qualified beat with `tlast`=1 closes the frame, returns to IDLE and clears the accumulator.
  - A single-beat frame goes IDLE to IDLE.
- **RX frame close**, using `len` = accumulator + last beat bytes:
  - `tuser`=1 increments `rx_good`; `tuser`=0 increments `rx_bad`.
  - `len` < `MIN_LEN` or `len` > `MAX_LEN` increments `rx_len_err`. This is in addition to the good/bad count.
  - `rx_max_len` becomes max(`rx_max_len`, `len`).
- **RX protocol error** (`proto_err` +1, at most once per beat) on a qualified beat with either:
  - `tkeep`=0; or
  - `tkeep` not of the form 2^k−1; or
  - `tlast`=0 with `tkeep`≠0xFF.
  - The beat's bytes are still counted.
- **TX counters**
  - Frame close increments `tx_frames`.
  - `tx_stall` counts cycles with `s_axis_tx_tvalid & !s_axis_tx_tready`.
- **Byte counters**: `rx_bytes` and `tx_bytes` add beat bytes on every qualified beat.
- **Widths and overflow**
  - Frame counters and `tx_stall`: 32 bits, wrap.
  - `rx_bytes`, `tx_bytes`, `uptime`: 64 bits, wrap.
  - `rx_len_err`, `proto_err`: 16 bits, saturate at 0xFFFF.
  - `uptime` increments every cycle.
  - `snap_seq` (16 bits, wraps) increments per snapshot.
- **`debug_vector` layout** (MSB first):
  - [383:320] `rx_good`, `rx_bad`
  - [319:256] `rx_bytes`
  - [255:192] `tx_frames`, `rx_len_err`, `proto_err`
  - [191:128] `tx_bytes`
  - [127:64] `tx_stall`, `rx_max_len`, `snap_seq`
  - [63:0] `uptime`
- **Snapshot**
  - The vector captures counter values *including* the events of the request cycle.
  - `snap_seq` in the vector is the post-increment value, so the first snapshot reads 1.
  - With `CLEAR_ON_SNAPSHOT`=1, every counter except `uptime` and `snap_seq` reloads with 0 in the request cycle, so the request cycle's events appear only in this snapshot.
  - In-progress frame accumulators are never cleared by a snapshot.
  - `snapshot` held high for N cycles produces N snapshots.

## Timing
- **Reset values**: all counters, accumulators, FSMs (IDLE), `debug_vector` and `snapshot_done` are 0.
- **Reset assertion mid-frame**: the partial frame is discarded. After release, beats are counted from the next qualified beat, even if that beat is mid-frame.
- **Event latency**: an event at edge N is reflected in the counters after edge N.
- **Snapshot latency**: `snapshot` high before edge N gives updated `debug_vector` and `snapshot_done`=1 during cycle N+1 (1-cycle latency).
- **Output stability**: `debug_vector` is stable between snapshots, so the consumer can sample it at any time.
- **Throughput**: one beat per cycle per direction, no bubbles. RX and TX events in the same cycle are independent.

## Structure
- **Package `nf_debug_pkg`**: word offsets of the six 64-bit lanes, field widths, saturation constants, meter state enum.
- **Sub-module `axis_frame_meter`**, instantiated twice (RX, TX):
  - popcount, IN_FRAME FSM, length accumulator;
  - outputs `beat_bytes`, `frame_close`, `frame_len`, `keep_err`.
- Counters, saturation and snapshot logic live in the top module.

## Test plan
- **Reset state**: after reset, pulse `snapshot` → `debug_vector` = 0 except `snap_seq`=1 and `uptime` = cycles since release; `snapshot_done` high for exactly one cycle.
- **Single good frame**: RX 8 beats `tkeep`=0xFF, last `tuser`=1, then snapshot → `rx_good`=1, `rx_bytes`=64, `rx_max_len`=64, `rx_len_err`=0, `proto_err`=0.
- **Runt and protocol error**: RX 1-beat frame `tkeep`=0x0F, `tuser`=0 → `rx_bad`=1, `rx_len_err`=1, `rx_bytes`=4. Then RX non-last beat `tkeep`=0x7F → `proto_err`=1.
- **TX back-pressure**: 11-beat TX frame with `tready` low for 3 cycles mid-frame → `tx_frames`=1, `tx_bytes`=88, `tx_stall`=3.
- **Clear on snapshot** (`CLEAR_ON_SNAPSHOT`=1): RX last beat coincides with `snapshot` → snapshot contains that frame; the next snapshot shows `rx_good`=0.
- **Saturation and wrap**: preload via 65,540 runts → `rx_len_err`=0xFFFF; force `tx_frames` to 0xFFFFFFFF plus one frame → 0.

Source files
------------

// File: rtl/nf_debug_pkg.sv
// Shared types and constants for the debug statistics collector:
// debug_vector lane offsets, counter widths, meter states and small helpers.
package nf_debug_pkg;

   localparam int unsigned LANE_W       = 64;
   localparam int unsigned VECTOR_W     = 6 * LANE_W;
   localparam int unsigned LANE_RX_FRM  = 5 * LANE_W;  // rx_good, rx_bad
   localparam int unsigned LANE_RX_BYTE = 4 * LANE_W;  // rx_bytes
   localparam int unsigned LANE_MISC    = 3 * LANE_W;  // tx_frames, rx_len_err, proto_err
   localparam int unsigned LANE_TX_BYTE = 2 * LANE_W;  // tx_bytes
   localparam int unsigned LANE_STALL   = 1 * LANE_W;  // tx_stall, rx_max_len, snap_seq
   localparam int unsigned LANE_UPTIME  = 0;           // uptime

   localparam int unsigned FRAME_CNT_W = 32;
   localparam int unsigned BYTE_CNT_W  = 64;
   localparam int unsigned SAT_CNT_W   = 16;
   localparam int unsigned LEN_W       = 16;
   localparam int unsigned SEQ_W       = 16;

   localparam logic [SAT_CNT_W-1:0] SAT16_MAX = 16'hFFFF;

   typedef enum logic {
      METER_IDLE     = 1'b0,
      METER_IN_FRAME = 1'b1
   } meter_state_t;

   function automatic logic [3:0] popcount8(input logic [7:0] v);
      logic [3:0] n;
      n = '0;
      for (int i = 0; i < 8; i++) n = n + {3'b000, v[i]};
      return n;
   endfunction

   function automatic logic [SAT_CNT_W-1:0] sat_inc16(input logic [SAT_CNT_W-1:0] v,
                                                      input logic inc);
      return (inc && (v != SAT16_MAX)) ? v + 16'd1 : v;
   endfunction

endpackage

// File: rtl/axis_frame_meter.sv
// Passive per-direction AXI-Stream frame meter: beat byte count, frame
// length accumulation (saturating) and keep-pattern sanity check.
module axis_frame_meter
   import nf_debug_pkg::*;
(
   input  logic             clk156,
   input  logic             reset,
   input  logic             beat,
   input  logic [7:0]       tkeep,
   input  logic             tlast,
   output logic [3:0]       beat_bytes,
   output logic             frame_close,
   output logic [LEN_W-1:0] frame_len,
   output logic             keep_err
);

   meter_state_t     state, state_nxt;
   logic [LEN_W-1:0] acc, acc_nxt;
   logic [LEN_W:0]   sum;

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk156 or posedge reset) begin
      if (reset) begin
         state <= METER_IDLE;
         acc   <= '0;
      end else begin
         state <= state_nxt;
         acc   <= acc_nxt;
      end
   end

   // NOTE: every output of this block is given a default first, so no path can infer a latch.
   always_comb begin
      beat_bytes  = popcount8(tkeep);
      sum         = {1'b0, acc} + {{(LEN_W-3){1'b0}}, beat_bytes};
      frame_len   = sum[LEN_W] ? SAT16_MAX : sum[LEN_W-1:0];
      frame_close = beat & tlast;
      keep_err    = beat & ((tkeep == 8'h00) ||
                            ((tkeep & (tkeep + 8'd1)) != 8'h00) ||
                            (!tlast && (tkeep != 8'hFF)));
      state_nxt   = state;
      acc_nxt     = acc;
      if (beat) begin
         if (tlast) begin
            state_nxt = METER_IDLE;
            acc_nxt   = '0;
         end else begin
            state_nxt = METER_IN_FRAME;
            acc_nxt   = frame_len;
         end
      end
   end

endmodule

// File: rtl/nf_debug_stats.sv
// Per-port RX/TX traffic statistics with an on-request coherent snapshot
// published on the 384-bit debug_vector.
module nf_debug_stats
   import nf_debug_pkg::*;
#(
   parameter int unsigned MIN_LEN           = 64,
   parameter int unsigned MAX_LEN           = 1518,
   parameter bit          CLEAR_ON_SNAPSHOT = 1'b0
) (
   input  logic                clk156,
   input  logic                reset,
   input  logic [7:0]          m_axis_rx_tkeep,
   input  logic                m_axis_rx_tlast,
   input  logic                m_axis_rx_tuser,
   input  logic                m_axis_rx_tvalid,
   input  logic [7:0]          s_axis_tx_tkeep,
   input  logic                s_axis_tx_tlast,
   input  logic                s_axis_tx_tvalid,
   input  logic                s_axis_tx_tready,
   input  logic                snapshot,
   output logic [VECTOR_W-1:0] debug_vector,
   output logic                snapshot_done
);

   localparam logic [LEN_W-1:0] MIN_LEN_L = LEN_W'(MIN_LEN);
   localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);

   logic                   rx_beat, tx_beat, rx_close, tx_close, rx_keep_err;
   logic [3:0]             rx_beat_bytes, tx_beat_bytes;
   logic [LEN_W-1:0]       rx_frame_len, tx_frame_len;
   logic                   tx_keep_err, unused_tx;

   logic [FRAME_CNT_W-1:0] rx_good, rx_bad, tx_frames, tx_stall;
   logic [FRAME_CNT_W-1:0] rx_good_nxt, rx_bad_nxt, tx_frames_nxt, tx_stall_nxt;
   logic [BYTE_CNT_W-1:0]  rx_bytes, tx_bytes, uptime;
   logic [BYTE_CNT_W-1:0]  rx_bytes_nxt, tx_bytes_nxt, uptime_nxt;
   logic [SAT_CNT_W-1:0]   rx_len_err, proto_err, rx_len_err_nxt, proto_err_nxt;
   logic [LEN_W-1:0]       rx_max_len, rx_max_len_nxt;
   logic [SEQ_W-1:0]       snap_seq, snap_seq_nxt;
   logic                   clear;

   assign rx_beat   = m_axis_rx_tvalid;
   assign tx_beat   = s_axis_tx_tvalid & s_axis_tx_tready;
   assign clear     = CLEAR_ON_SNAPSHOT && snapshot;
   assign unused_tx = ^{tx_frame_len, tx_keep_err};

   axis_frame_meter u_rx_meter (
      .clk156      (clk156),
      .reset       (reset),
      .beat        (rx_beat),
      .tkeep       (m_axis_rx_tkeep),
      .tlast       (m_axis_rx_tlast),
      .beat_bytes  (rx_beat_bytes),
      .frame_close (rx_close),
      .frame_len   (rx_frame_len),
      .keep_err    (rx_keep_err)
   );

   axis_frame_meter u_tx_meter (
      .clk156      (clk156),
      .reset       (reset),
      .beat        (tx_beat),
      .tkeep       (s_axis_tx_tkeep),
      .tlast       (s_axis_tx_tlast),
      .beat_bytes  (tx_beat_bytes),
      .frame_close (tx_close),
      .frame_len   (tx_frame_len),
      .keep_err    (tx_keep_err)
   );

   always_comb begin
      rx_good_nxt    = rx_good;
      rx_bad_nxt     = rx_bad;
      rx_bytes_nxt   = rx_bytes;
      rx_len_err_nxt = rx_len_err;
      rx_max_len_nxt = rx_max_len;
      tx_frames_nxt  = tx_frames;
      tx_bytes_nxt   = tx_bytes;
      tx_stall_nxt   = tx_stall;
      if (rx_close) begin
         if (m_axis_rx_tuser) rx_good_nxt = rx_good + 32'd1;
         else                 rx_bad_nxt  = rx_bad + 32'd1;
         rx_len_err_nxt = sat_inc16(rx_len_err,
                                    (rx_frame_len < MIN_LEN_L) || (rx_frame_len > MAX_LEN_L));
         if (rx_frame_len > rx_max_len) rx_max_len_nxt = rx_frame_len;
      end
      if (rx_beat)  rx_bytes_nxt  = rx_bytes + BYTE_CNT_W'(rx_beat_bytes);
      proto_err_nxt = sat_inc16(proto_err, rx_keep_err);
      if (tx_close) tx_frames_nxt = tx_frames + 32'd1;
      if (tx_beat)  tx_bytes_nxt  = tx_bytes + BYTE_CNT_W'(tx_beat_bytes);
      if (s_axis_tx_tvalid && !s_axis_tx_tready) tx_stall_nxt = tx_stall + 32'd1;
      uptime_nxt   = uptime + 64'd1;
      snap_seq_nxt = snap_seq + SEQ_W'(snapshot);
   end

   // The snapshot captures the next-state values so request-cycle events are included.
   always_ff @(posedge clk156 or posedge reset) begin
      if (reset) begin
         rx_good       <= '0;
         rx_bad        <= '0;
         rx_bytes      <= '0;
         rx_len_err    <= '0;
         proto_err     <= '0;
         rx_max_len    <= '0;
         tx_frames     <= '0;
         tx_bytes      <= '0;
         tx_stall      <= '0;
         uptime        <= '0;
         snap_seq      <= '0;
         debug_vector  <= '0;
         snapshot_done <= 1'b0;
      end else begin
         rx_good       <= clear ? '0 : rx_good_nxt;
         rx_bad        <= clear ? '0 : rx_bad_nxt;
         rx_bytes      <= clear ? '0 : rx_bytes_nxt;
         rx_len_err    <= clear ? '0 : rx_len_err_nxt;
         proto_err     <= clear ? '0 : proto_err_nxt;
         rx_max_len    <= clear ? '0 : rx_max_len_nxt;
         tx_frames     <= clear ? '0 : tx_frames_nxt;
         tx_bytes      <= clear ? '0 : tx_bytes_nxt;
         tx_stall      <= clear ? '0 : tx_stall_nxt;
         uptime        <= uptime_nxt;
         snap_seq      <= snap_seq_nxt;
         snapshot_done <= snapshot;
         if (snapshot) begin
            debug_vector <= {rx_good_nxt, rx_bad_nxt, rx_bytes_nxt,
                             tx_frames_nxt, rx_len_err_nxt, proto_err_nxt,
                             tx_bytes_nxt, tx_stall_nxt, rx_max_len_nxt, snap_seq_nxt,
                             uptime_nxt};
         end
      end
   end

endmodule

// File: tb/tb_nf_debug_stats.sv
// Directed bench for nf_debug_stats: one free-running and one clear-on-snapshot instance.
module tb_nf_debug_stats;

   logic         clk156 = 1'b0;
   logic         reset;
   logic [7:0]   m_axis_rx_tkeep;
   logic         m_axis_rx_tlast, m_axis_rx_tuser, m_axis_rx_tvalid;
   logic [7:0]   s_axis_tx_tkeep;
   logic         s_axis_tx_tlast, s_axis_tx_tvalid, s_axis_tx_tready;
   logic         snapshot;
   logic [383:0] debug_vector, debug_vector_c;
   logic         snapshot_done, snapshot_done_c;

   int checks   = 0;
   int failures = 0;

   always #5 clk156 = ~clk156;

   nf_debug_stats #(.MIN_LEN(64), .MAX_LEN(1518), .CLEAR_ON_SNAPSHOT(1'b0)) dut (
      .clk156(clk156), .reset(reset),
      .m_axis_rx_tkeep(m_axis_rx_tkeep), .m_axis_rx_tlast(m_axis_rx_tlast),
      .m_axis_rx_tuser(m_axis_rx_tuser), .m_axis_rx_tvalid(m_axis_rx_tvalid),
      .s_axis_tx_tkeep(s_axis_tx_tkeep), .s_axis_tx_tlast(s_axis_tx_tlast),
      .s_axis_tx_tvalid(s_axis_tx_tvalid), .s_axis_tx_tready(s_axis_tx_tready),
      .snapshot(snapshot), .debug_vector(debug_vector), .snapshot_done(snapshot_done)
   );

   nf_debug_stats #(.MIN_LEN(64), .MAX_LEN(1518), .CLEAR_ON_SNAPSHOT(1'b1)) dut_c (
      .clk156(clk156), .reset(reset),
      .m_axis_rx_tkeep(m_axis_rx_tkeep), .m_axis_rx_tlast(m_axis_rx_tlast),
      .m_axis_rx_tuser(m_axis_rx_tuser), .m_axis_rx_tvalid(m_axis_rx_tvalid),
      .s_axis_tx_tkeep(s_axis_tx_tkeep), .s_axis_tx_tlast(s_axis_tx_tlast),
      .s_axis_tx_tvalid(s_axis_tx_tvalid), .s_axis_tx_tready(s_axis_tx_tready),
      .snapshot(snapshot), .debug_vector(debug_vector_c), .snapshot_done(snapshot_done_c)
   );

   // Expected upper 320 bits of debug_vector (everything but uptime).
   function automatic logic [319:0] pack_exp(
      input logic [31:0] good, input logic [31:0] bad, input logic [63:0] rxb,
      input logic [31:0] txf, input logic [15:0] lerr, input logic [15:0] perr,
      input logic [63:0] txb, input logic [31:0] stall, input logic [15:0] maxl,
      input logic [15:0] seq);
      return {good, bad, rxb, txf, lerr, perr, txb, stall, maxl, seq};
   endfunction

   task automatic idle_inputs();
      m_axis_rx_tvalid = 1'b0; m_axis_rx_tkeep = 8'h00; m_axis_rx_tlast = 1'b0; m_axis_rx_tuser = 1'b0;
      s_axis_tx_tvalid = 1'b0; s_axis_tx_tkeep = 8'h00; s_axis_tx_tlast = 1'b0; s_axis_tx_tready = 1'b0;
      snapshot = 1'b0;
   endtask

   task automatic apply_reset();
      idle_inputs();
      reset = 1'b1;
      repeat (2) @(negedge clk156);
      reset = 1'b0;
   endtask

   task automatic rx_beat(input logic [7:0] keep, input logic last, input logic user, input logic snap);
      m_axis_rx_tvalid = 1'b1; m_axis_rx_tkeep = keep; m_axis_rx_tlast = last; m_axis_rx_tuser = user;
      snapshot = snap;
      @(negedge clk156);
      m_axis_rx_tvalid = 1'b0; m_axis_rx_tkeep = 8'h00; m_axis_rx_tlast = 1'b0; m_axis_rx_tuser = 1'b0;
      snapshot = 1'b0;
   endtask

   task automatic rx_frame(input int full_beats, input logic [7:0] last_keep, input logic user);
      repeat (full_beats) rx_beat(8'hFF, 1'b0, 1'b0, 1'b0);
      rx_beat(last_keep, 1'b1, user, 1'b0);
   endtask

   task automatic tx_cycle(input logic valid, input logic ready, input logic [7:0] keep, input logic last);
      s_axis_tx_tvalid = valid; s_axis_tx_tready = ready; s_axis_tx_tkeep = keep; s_axis_tx_tlast = last;
      @(negedge clk156);
      s_axis_tx_tvalid = 1'b0; s_axis_tx_tready = 1'b0; s_axis_tx_tkeep = 8'h00; s_axis_tx_tlast = 1'b0;
   endtask

   task automatic take_snapshot(output logic [383:0] v, output logic [383:0] vc,
                                output logic done, output logic done_c);
      snapshot = 1'b1;
      @(negedge clk156);
      snapshot = 1'b0;
      v = debug_vector; vc = debug_vector_c; done = snapshot_done; done_c = snapshot_done_c;
   endtask

   task automatic test_reset();
      logic [383:0] v, vc, exp;
      logic d, dc;
      apply_reset();
      checks++;
      if (debug_vector !== 384'd0) begin
         failures++; $display("FAIL reset_vector got %h expected 0", debug_vector);
      end
      checks++;
      if (snapshot_done !== 1'b0) begin
         failures++; $display("FAIL reset_done got %b expected 0", snapshot_done);
      end
      repeat (3) @(negedge clk156);
      take_snapshot(v, vc, d, dc);
      exp = {pack_exp(32'd0, 32'd0, 64'd0, 32'd0, 16'd0, 16'd0, 64'd0, 32'd0, 16'd0, 16'd1), 64'd4};
      checks++;
      if (v !== exp) begin
         failures++; $display("FAIL reset_snapshot got %h expected %h", v, exp);
      end
      checks++;
      if (d !== 1'b1) begin
         failures++; $display("FAIL reset_done_pulse got %b expected 1", d);
      end
      @(negedge clk156);
      checks++;
      if (snapshot_done !== 1'b0 || debug_vector !== exp) begin
         failures++; $display("FAIL reset_done_one_cycle done=%b vec=%h expected done=0 vec=%h",
                              snapshot_done, debug_vector, exp);
      end
   endtask

   task automatic test_good_frame();
      logic [383:0] v, vc;
      logic [319:0] exp;
      logic d, dc;
      apply_reset();
      rx_frame(7, 8'hFF, 1'b1);
      take_snapshot(v, vc, d, dc);
      exp = pack_exp(32'd1, 32'd0, 64'd64, 32'd0, 16'd0, 16'd0, 64'd0, 32'd0, 16'd64, 16'd1);
      checks++;
      if (v[383:64] !== exp || d !== 1'b1) begin
         failures++; $display("FAIL good_frame got %h done=%b expected %h done=1", v[383:64], d, exp);
      end
   endtask

   task automatic test_runt_proto();
      logic [383:0] v, vc;
      logic [319:0] exp;
      logic d, dc;
      apply_reset();
      m_axis_rx_tkeep = 8'h00; m_axis_rx_tlast = 1'b1; m_axis_rx_tuser = 1'b1;
      s_axis_tx_tready = 1'b1; s_axis_tx_tlast = 1'b1; s_axis_tx_tkeep = 8'hFF;
      @(negedge clk156);
      idle_inputs();
      rx_beat(8'h0F, 1'b1, 1'b0, 1'b0);
      take_snapshot(v, vc, d, dc);
      exp = pack_exp(32'd0, 32'd1, 64'd4, 32'd0, 16'd1, 16'd0, 64'd0, 32'd0, 16'd4, 16'd1);
      checks++;
      if (v[383:64] !== exp) begin
         failures++; $display("FAIL runt got %h expected %h", v[383:64], exp);
      end
      rx_beat(8'h7F, 1'b0, 1'b0, 1'b0);
      take_snapshot(v, vc, d, dc);
      exp = pack_exp(32'd0, 32'd1, 64'd11, 32'd0, 16'd1, 16'd1, 64'd0, 32'd0, 16'd4, 16'd2);
      checks++;
      if (v[383:64] !== exp) begin
         failures++; $display("FAIL proto_nonlast got %h expected %h", v[383:64], exp);
      end
      rx_beat(8'h05, 1'b1, 1'b1, 1'b0);
      take_snapshot(v, vc, d, dc);
      exp = pack_exp(32'd1, 32'd1, 64'd13, 32'd0, 16'd2, 16'd2, 64'd0, 32'd0, 16'd9, 16'd3);
      checks++;
      if (v[383:64] !== exp) begin
         failures++; $display("FAIL proto_pattern got %h expected %h", v[383:64], exp);
      end
   endtask

   task automatic test_tx_backpressure();
      logic [383:0] v, vc;
      logic [319:0] exp;
      logic d, dc;
      apply_reset();
      repeat (5) tx_cycle(1'b1, 1'b1, 8'hFF, 1'b0);
      repeat (3) tx_cycle(1'b1, 1'b0, 8'hFF, 1'b1);
      repeat (5) tx_cycle(1'b1, 1'b1, 8'hFF, 1'b0);
      tx_cycle(1'b1, 1'b1, 8'hFF, 1'b1);
      tx_cycle(1'b0, 1'b1, 8'hFF, 1'b1);
      take_snapshot(v, vc, d, dc);
      exp = pack_exp(32'd0, 32'd0, 64'd0, 32'd1, 16'd0, 16'd0, 64'd88, 32'd3, 16'd0, 16'd1);
      checks++;
      if (v[383:64] !== exp) begin
         failures++; $display("FAIL tx_backpressure got %h expected %h", v[383:64], exp);
      end
      checks++;
      if (d !== 1'b1) begin
         failures++; $display("FAIL tx_snapshot_done got %b expected 1", d);
      end
   endtask

   task automatic test_back_to_back();
      logic [319:0] exp;
      apply_reset();
      rx_frame(7, 8'hFF, 1'b1);
      rx_frame(189, 8'h3F, 1'b1);
      rx_frame(189, 8'h7F, 1'b1);
      rx_frame(7, 8'h7F, 1'b1);
      snapshot = 1'b1;
      @(negedge clk156);
      exp = pack_exp(32'd4, 32'd0, 64'd3164, 32'd0, 16'd2, 16'd0, 64'd0, 32'd0, 16'd1519, 16'd1);
      checks++;
      if (debug_vector[383:64] !== exp || snapshot_done !== 1'b1) begin
         failures++; $display("FAIL b2b_first got %h done=%b expected %h done=1",
                              debug_vector[383:64], snapshot_done, exp);
      end
      @(negedge clk156);
      snapshot = 1'b0;
      checks++;
      if (debug_vector[79:64] !== 16'd2 || snapshot_done !== 1'b1) begin
         failures++; $display("FAIL b2b_held_seq got seq=%0d done=%b expected seq=2 done=1",
                              debug_vector[79:64], snapshot_done);
      end
      checks++;
      if (debug_vector[383:80] !== exp[319:16]) begin
         failures++; $display("FAIL b2b_held_counters got %h expected %h",
                              debug_vector[383:80], exp[319:16]);
      end
      @(negedge clk156);
      checks++;
      if (snapshot_done !== 1'b0) begin
         failures++; $display("FAIL b2b_done_drop got %b expected 0", snapshot_done);
      end
   endtask

   task automatic test_reset_mid_frame();
      logic [383:0] v, vc;
      logic [319:0] exp;
      logic d, dc;
      apply_reset();
      repeat (3) rx_beat(8'hFF, 1'b0, 1'b0, 1'b0);
      reset = 1'b1;
      @(negedge clk156);
      reset = 1'b0;
      rx_frame(4, 8'hFF, 1'b1);
      take_snapshot(v, vc, d, dc);
      exp = pack_exp(32'd1, 32'd0, 64'd40, 32'd0, 16'd1, 16'd0, 64'd0, 32'd0, 16'd40, 16'd1);
      checks++;
      if (v[383:64] !== exp) begin
         failures++; $display("FAIL reset_mid_frame got %h expected %h", v[383:64], exp);
      end
   endtask

   task automatic test_clear_on_snapshot();
      logic [383:0] v, vc;
      logic [319:0] exp;
      logic d, dc;
      apply_reset();
      repeat (7) rx_beat(8'hFF, 1'b0, 1'b0, 1'b0);
      rx_beat(8'hFF, 1'b1, 1'b1, 1'b1);
      exp = pack_exp(32'd1, 32'd0, 64'd64, 32'd0, 16'd0, 16'd0, 64'd0, 32'd0, 16'd64, 16'd1);
      checks++;
      if (debug_vector_c[383:64] !== exp || snapshot_done_c !== 1'b1) begin
         failures++; $display("FAIL clear_same_cycle got %h done=%b expected %h done=1",
                              debug_vector_c[383:64], snapshot_done_c, exp);
      end
      take_snapshot(v, vc, d, dc);
      exp = pack_exp(32'd0, 32'd0, 64'd0, 32'd0, 16'd0, 16'd0, 64'd0, 32'd0, 16'd0, 16'd2);
      checks++;
      if (vc[383:64] !== exp) begin
         failures++; $display("FAIL clear_next got %h expected %h", vc[383:64], exp);
      end
      repeat (4) rx_beat(8'hFF, 1'b0, 1'b0, 1'b0);
      take_snapshot(v, vc, d, dc);
      exp = pack_exp(32'd0, 32'd0, 64'd32, 32'd0, 16'd0, 16'd0, 64'd0, 32'd0, 16'd0, 16'd3);
      checks++;
      if (vc[383:64] !== exp) begin
         failures++; $display("FAIL clear_mid_frame got %h expected %h", vc[383:64], exp);
      end
      rx_frame(3, 8'hFF, 1'b1);
      take_snapshot(v, vc, d, dc);
      exp = pack_exp(32'd1, 32'd0, 64'd32, 32'd0, 16'd0, 16'd0, 64'd0, 32'd0, 16'd64, 16'd4);
      checks++;
      if (vc[383:64] !== exp) begin
         failures++; $display("FAIL clear_keeps_accum got %h expected %h", vc[383:64], exp);
      end
      checks++;
      if (v[383:352] !== 32'd2) begin
         failures++; $display("FAIL free_running_good got %0d expected 2", v[383:352]);
      end
   endtask

   task automatic test_saturation();
      logic [383:0] v, vc;
      logic [319:0] exp;
      logic d, dc;
      apply_reset();
      m_axis_rx_tvalid = 1'b1; m_axis_rx_tkeep = 8'h00; m_axis_rx_tlast = 1'b1; m_axis_rx_tuser = 1'b0;
      repeat (65540) @(negedge clk156);
      idle_inputs();
      take_snapshot(v, vc, d, dc);
      exp = pack_exp(32'd0, 32'd65540, 64'd0, 32'd0, 16'hFFFF, 16'hFFFF, 64'd0, 32'd0, 16'd0, 16'd1);
      checks++;
      if (v[383:64] !== exp) begin
         failures++; $display("FAIL saturation got %h expected %h", v[383:64], exp);
      end
      force dut.tx_frames = 32'hFFFF_FFFF;
      @(negedge clk156);
      release dut.tx_frames;
      tx_cycle(1'b1, 1'b1, 8'hFF, 1'b1);
      take_snapshot(v, vc, d, dc);
      exp = pack_exp(32'd0, 32'd65540, 64'd0, 32'd0, 16'hFFFF, 16'hFFFF, 64'd8, 32'd0, 16'd0, 16'd2);
      checks++;
      if (v[383:64] !== exp) begin
         failures++; $display("FAIL tx_frames_wrap got %h expected %h", v[383:64], exp);
      end
   endtask

   initial begin
      idle_inputs();
      reset = 1'b1;
      test_reset();
      test_good_frame();
      test_runt_proto();
      test_tx_backpressure();
      test_back_to_back();
      test_reset_mid_frame();
      test_clear_on_snapshot();
      test_saturation();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
